stream_channel_summer: RTL
==========================

Name: stream_channel_summer

Overview:
- Parametrised multi-channel Avalon-ST decimating accumulator.
- Sits between the ADC capture FIFO output and the dsp streaming sink.
- Sums DECIM consecutive signed samples per channel and emits one widened sum per channel per DECIM samples.
- Has a small output FIFO with backpressure, drop counting and an Avalon-MM slave for configuration and status.

Parameters:
- DATA_W, 16, sample width; signed two's complement.
- CHANNELS, 4, number of independent channels (1..16).
- CH_W, 2, channel field width; must satisfy 2^CH_W >= CHANNELS.
- DECIM_W, 8, decimation register width; max DECIM = 2^DECIM_W-1.
- ACC_W, DATA_W+DECIM_W, accumulator and output width.
- OUT_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- avalon_streaming_sink_valid  in  1  input sample valid.
- avalon_streaming_sink_data  in  DATA_W  signed input sample.
- avalon_streaming_sink_channel  in  CH_W  input sample channel.
- avalon_streaming_source_valid  out  1  output sum valid.
- avalon_streaming_source_data  out  ACC_W  signed channel sum.
- avalon_streaming_source_channel  out  CH_W  channel of the sum.
- avalon_streaming_source_ready  in  1  downstream accepts the beat.
- avalon_slave_address  in  2  register select.
- avalon_slave_read  in  1  register read strobe.
- avalon_slave_write  in  1  register write strobe.
- avalon_slave_writedata  in  32  write data.
- avalon_slave_readdata  out  32  read data; valid the cycle after read.

Behaviour:
- Reset (async, active-high):
  - All accumulators and per-channel counters = 0; output FIFO empty.
  - source_valid=0, source_data=0, source_channel=0, readdata=0.
  - enable=0, DECIM=1, drop_cnt=0.
- Registers:
  - addr0 CTRL: bit0 enable (R/W); bit1 clear (write-1, self-clearing, reads 0).
  - addr1 DECIM: R/W, bits[DECIM_W-1:0]; writing 0 stores 1.
  - addr2 DROPS: read returns drop_cnt (32-bit, saturating); any write clears it.
  - addr3 STATUS: bits[3:0] FIFO level; bit8 FIFO full; bit9 FIFO empty.
- A write to DECIM or a clear zeroes all accumulators and counters in the same cycle. The output FIFO is untouched.
- An input beat is accepted when sink_valid=1, enable=1 and channel<CHANNELS.
  - Beats with channel>=CHANNELS are ignored: no state change.
  - With enable=0 all beats are ignored and accumulators hold their values.
- Arithmetic:
  - Sample is sign-extended to ACC_W.
  - On an accepted beat for channel c: sum = acc[c] + sample.
  - If cnt[c] == DECIM-1: push {c, sum} into the output FIFO, then acc[c]=0 and cnt[c]=0.
  - Otherwise: acc[c]=sum, cnt[c]=cnt[c]+1.
  - No overflow is possible by construction; no saturation logic.
- Latency: a completing input beat at cycle N appears at source_valid by cycle N+1 if the FIFO was empty.
- Sink has no ready signal: one beat per cycle is sustained at full rate.
- Output FIFO full (OUT_DEPTH entries) when a push is due, with no pop in the same cycle:
  - The sum is dropped and drop_cnt increments.
  - acc[c] and cnt[c] still reset to 0.
- Full with a pop in the same cycle: the push succeeds.
- Source handshake:
  - A beat transfers when source_valid && source_ready.
  - data and channel are stable while valid=1 and ready=0.
  - The head entry is popped on transfer.
- CHANNELS=1: channel input is ignored (treated as 0).
- DECIM=1: every accepted sample passes through sign-extended, one cycle later.
- Reset mid-operation: immediate return to reset values. Partial sums and buffered outputs are lost.

Test Plan:
- DECIM=4, enable=1, ch0 samples 1,2,3,4 on consecutive cycles, ready=1 -> one beat ch0 data=10, one cycle after the 4th sample; no other beats.
- DECIM=2, interleaved ch0:-5, ch1:7, ch0:-3, ch1:1 -> beats ch0 data=-8 (ACC_W sign-extended) then ch1 data=8.
- DECIM=1, ready=0, six samples on ch2 (OUT_DEPTH=4) -> STATUS level=4, full=1, DROPS=2. Raise ready -> first four samples delivered in order; then write DROPS -> reads 0.
- DECIM=3, two ch1 samples, then write DECIM=3 again, then samples 5,5,5 -> single beat data=15; the earlier partial sum is discarded.
- Samples with channel=5 (CHANNELS=4) and samples while enable=0 -> no output, accumulators unchanged. Next valid sequence sums correctly.
- reset asserted while FIFO holds 2 entries and ch0 holds a partial sum -> source_valid=0 immediately; post-reset DECIM reads 1 and STATUS empty=1.

Source files
------------

// File: rtl/stream_channel_summer.sv
// Multi-channel decimating accumulator: sums DECIM signed samples per channel and
// streams one widened sum per channel through a small output FIFO with drop counting.
module stream_channel_summer #(
  parameter int DATA_W    = 16,
  parameter int CHANNELS  = 4,
  parameter int CH_W      = 2,
  parameter int DECIM_W   = 8,
  parameter int ACC_W     = DATA_W + DECIM_W,
  parameter int OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                avalon_streaming_sink_valid,
  input  logic [DATA_W-1:0]   avalon_streaming_sink_data,
  input  logic [CH_W-1:0]     avalon_streaming_sink_channel,
  output logic                avalon_streaming_source_valid,
  output logic [ACC_W-1:0]    avalon_streaming_source_data,
  output logic [CH_W-1:0]     avalon_streaming_source_channel,
  input  logic                avalon_streaming_source_ready,
  input  logic [1:0]          avalon_slave_address,
  input  logic                avalon_slave_read,
  input  logic                avalon_slave_write,
  input  logic [31:0]         avalon_slave_writedata,
  output logic [31:0]         avalon_slave_readdata
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [ACC_W-1:0] data;
  } beat_t;

  logic                enable;
  logic [DECIM_W-1:0]  decim;
  logic [31:0]         drop_cnt;
  logic [ACC_W-1:0]    acc [CHANNELS];
  logic [DECIM_W-1:0]  cnt [CHANNELS];

  beat_t               fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;

  logic                wr_ctrl;
  logic                wr_decim;
  logic                wr_drops;
  logic                acc_clear;
  logic                ch_ok;
  logic                accept;
  logic [IDX_W-1:0]    ch_idx;
  logic [CH_W-1:0]     push_ch;
  logic [ACC_W-1:0]    sample_ext;
  logic [ACC_W-1:0]    sum;
  logic                complete;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                drop;
  logic [DECIM_W-1:0]  decim_wr;
  logic [3:0]          level_nib;
  logic [31:0]         rd_mux;
  beat_t               head;
  logic                unused_wdata;

  assign unused_wdata = ^avalon_slave_writedata;

  assign wr_ctrl   = avalon_slave_write && (avalon_slave_address == 2'd0);
  assign wr_decim  = avalon_slave_write && (avalon_slave_address == 2'd1);
  assign wr_drops  = avalon_slave_write && (avalon_slave_address == 2'd2);
  // A decimation change or explicit clear restarts every partial sum; a beat in that cycle is discarded
  assign acc_clear = wr_decim || (wr_ctrl && avalon_slave_writedata[1]);

  assign ch_ok   = (CHANNELS == 1) ? 1'b1 : ({1'b0, avalon_streaming_sink_channel} < CH_LIMIT);
  assign accept  = avalon_streaming_sink_valid && enable && ch_ok && !acc_clear;
  assign ch_idx  = (CHANNELS == 1) ? '0 : avalon_streaming_sink_channel[IDX_W-1:0];
  assign push_ch = (CHANNELS == 1) ? '0 : avalon_streaming_sink_channel;

  assign sample_ext = {{(ACC_W - DATA_W){avalon_streaming_sink_data[DATA_W-1]}},
                       avalon_streaming_sink_data};
  assign sum        = acc[ch_idx] + sample_ext;
  assign complete   = (cnt[ch_idx] == (decim - DECIM_W'(1)));

  assign fifo_full  = (level == LVL_W'(OUT_DEPTH));
  assign fifo_empty = (level == '0);
  assign pop        = !fifo_empty && avalon_streaming_source_ready;
  // A full FIFO can still take the sum when the head leaves in the same cycle
  assign push_req   = accept && complete;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  assign head                            = fifo_mem[rd_ptr];
  assign avalon_streaming_source_valid   = !fifo_empty;
  assign avalon_streaming_source_data    = fifo_empty ? '0 : head.data;
  assign avalon_streaming_source_channel = fifo_empty ? '0 : head.ch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (acc_clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (accept) begin
      if (complete) begin
        acc[ch_idx] <= '0;
        cnt[ch_idx] <= '0;
      end else begin
        acc[ch_idx] <= sum;
        cnt[ch_idx] <= cnt[ch_idx] + DECIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{ch: push_ch, data: sum};
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign decim_wr  = avalon_slave_writedata[DECIM_W-1:0];
  assign level_nib = 4'(level);

  always_comb begin
    rd_mux = '0;
    case (avalon_slave_address)
      2'd0:    rd_mux = {31'b0, enable};
      2'd1:    rd_mux = 32'(decim);
      2'd2:    rd_mux = drop_cnt;
      default: rd_mux = {22'b0, fifo_empty, fifo_full, 4'b0, level_nib};
    endcase
  end

  // Drop counter saturates so a long stall never wraps back to a small value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable                <= 1'b0;
      decim                 <= DECIM_W'(1);
      drop_cnt              <= '0;
      avalon_slave_readdata <= '0;
    end else begin
      if (wr_ctrl) begin
        enable <= avalon_slave_writedata[0];
      end
      if (wr_decim) begin
        decim <= (decim_wr == '0) ? DECIM_W'(1) : decim_wr;
      end
      if (wr_drops) begin
        drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
      if (avalon_slave_read) begin
        avalon_slave_readdata <= rd_mux;
      end
    end
  end

endmodule
